// File: rtl/mux_rr_pipe.sv
// -----------------------------------------------------------------------------
// mux_rr_pipe
//
// Registered N:1 channel multiplexer with per-channel valid/ready handshake and
// a one-entry output register. The channel is picked each cycle either by a
// directed index (mode=0, sel) or by round-robin arbitration among the valid
// channels (mode=1). The picked word appears on the output one cycle after its
// input handshake.
//
// Parameters
//   NUM_IN  number of input channels (2..64)
//   DATA_W  width of one channel data word
//   SEL_W   derived: width of sel / out_ch ($clog2(NUM_IN))
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = directed (sel), 1 = round-robin
//   sel        channel index used in directed mode
//   in_valid   per-channel valid, bit i = channel i
//   in_data    flattened channel data, channel i at [i*DATA_W +: DATA_W]
//   in_ready   per-channel ready (combinational, at most one bit high)
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_ch     index of the channel that supplied out_data
//   out_ready  consumer accepts the word this cycle
//   sel_err    (only with MUX_RR_SEL_ERR_EN) sticky flag: directed mode saw an
//              out-of-range sel while some channel was valid
//
// Optional feature macro: MUX_RR_SEL_ERR_EN
// -----------------------------------------------------------------------------
module mux_rr_pipe #(
  parameter int  NUM_IN = 31,
  parameter int  DATA_W = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
`ifdef MUX_RR_SEL_ERR_EN
  ,
  output logic                     sel_err
`endif
);

  // NUM_IN expressed one bit wider than sel so sel codes >= NUM_IN compare cleanly
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic              load_en_s;
  logic              sel_ok_s;
  logic [NUM_IN-1:0] dir_grant_s;
  logic [NUM_IN-1:0] rr_grant_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic [NUM_IN-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [NUM_IN-1:0] in_ready_s;
  logic              xfer_s;
  logic [DATA_W-1:0] sel_data_s;

  // Output register can take a word when empty or drained this same cycle
  assign load_en_s = ~out_valid_q | out_ready;
  assign sel_ok_s  = ({1'b0, sel} < NUM_IN_L);

  // Directed grant: only the channel addressed by an in-range sel, if valid
  always_comb begin
    dir_grant_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dir_grant_s[i] = sel_ok_s & (sel == SEL_W'(i)) & in_valid[i];
    end
  end

  // Round-robin grant: scan starts just above rr_ptr. Split into an upper pass
  // (channels above rr_ptr) and a wrapped lower pass (channels 0..rr_ptr); the
  // first valid channel found in that order wins.
  always_comb begin : rr_scan
    logic found;
    logic take;
    found      = 1'b0;
    take       = 1'b0;
    rr_grant_s = '0;
    rr_idx_s   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      take          = in_valid[i] & (SEL_W'(i) > rr_ptr_q) & ~found;
      rr_grant_s[i] = take;
      rr_idx_s      = rr_idx_s | (SEL_W'(i) & {SEL_W{take}});
      found         = found | take;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      take          = in_valid[i] & (SEL_W'(i) <= rr_ptr_q) & ~found;
      rr_grant_s[i] = rr_grant_s[i] | take;
      rr_idx_s      = rr_idx_s | (SEL_W'(i) & {SEL_W{take}});
      found         = found | take;
    end
  end

  // Mode selects which arbiter drives the grant
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    if (mode) begin
      grant_s     = rr_grant_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = dir_grant_s;
      grant_idx_s = sel;
    end
  end

  // Ready follows the grant only when the output register can load; reset
  // pulls every ready low immediately so no handshake completes during reset.
  always_comb begin
    in_ready_s = '0;
    if (reset || !load_en_s) begin
      in_ready_s = '0;
    end else begin
      in_ready_s = grant_s;
    end
  end

  assign in_ready = in_ready_s;
  assign xfer_s   = |in_ready_s;

  // Data mux: grant is one-hot, so an AND-OR reduction selects the word
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data_s = sel_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en_s) begin
      out_valid_d = xfer_s;
      if (xfer_s) begin
        out_data_d = sel_data_s;
        out_ch_d   = grant_idx_s;
      end else begin
        // empty cycle: data and channel keep their last values
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
      end
    end else begin
      // backpressure: hold the current word
      out_valid_d = out_valid_q;
    end
    // pointer only moves on a round-robin transfer; kept across mode switches
    if (xfer_s && mode) begin
      rr_ptr_d = grant_idx_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Output register and pointer; LAST_CH reset gives channel 0 first priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= LAST_CH;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_RR_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky flag: directed mode with an unused sel code while a producer waits
  always_comb begin
    sel_err_d = sel_err_q;
    if (!mode && !sel_ok_s && (|in_valid)) begin
      sel_err_d = 1'b1;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_rr_pipe.sv
module tb_mux_rr_pipe;

  localparam int N = 31;
  localparam int W = 2;

  logic           clk;
  logic           reset;
  logic           mode;
  logic [4:0]     sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [4:0]     out_ch;
  logic           out_ready;
`ifdef MUX_RR_SEL_ERR_EN
  logic           sel_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;
  logic         m_err;

  mux_rr_pipe #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef MUX_RR_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which channel the rules pick: directed index, or first valid after ptr (circular)
  function automatic int ref_grant(input logic m, input logic [4:0] s,
                                   input logic [N-1:0] v, input int ptr);
    if (!m) begin
      if (int'(s) < N && v[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = ref_grant(mode, sel, in_valid, m_ptr);
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = N - 1;
    m_err   = 1'b0;
  endtask

  // Advance one clock edge, updating the model from pre-edge inputs
  task automatic step();
    int   g;
    logic ld;
    logic e;
    g  = ref_grant(mode, sel, in_valid, m_ptr);
    ld = !m_valid || out_ready;
    e  = !mode && (int'(sel) >= N) && (in_valid != '0);
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        if (mode) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (e) m_err = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  task automatic test_reset();
    mode = 1'b1; sel = 5'd0; in_valid = '1; in_data = '1; out_ready = 1'b1;
    reset = 1'b1;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || out_ch !== 5'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b d=%0d ch=%0d, want 0/0/0", out_valid, out_data, out_ch);
    end
    n_cmp++;
    if (in_ready !== 31'd0) begin
      n_err++;
      $display("FAIL reset_in_ready: got %h, want 0", in_ready);
    end
`ifdef MUX_RR_SEL_ERR_EN
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sel_err: got %0b, want 0", sel_err);
    end
`endif
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (in_ready !== 31'd1) begin
      n_err++;
      $display("FAIL reset_first_grant: got %h, want 1", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 5'd0) begin
      n_err++;
      $display("FAIL reset_first_out: got v=%0b ch=%0d, want 1/0", out_valid, out_ch);
    end
  endtask

  task automatic test_directed();
    do_reset();
    mode = 1'b0; out_ready = 1'b1; sel = 5'd12;
    in_valid = '0; in_valid[12] = 1'b1; in_valid[13] = 1'b1;
    in_data = '0; set_ch(12, 2'b10); set_ch(13, 2'b01);
    #1;
    n_cmp++;
    if (in_ready !== (31'd1 << 12)) begin
      n_err++;
      $display("FAIL directed_ready: got %h, want %h", in_ready, 31'd1 << 12);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 2'b10 || out_ch !== 5'd12) begin
      n_err++;
      $display("FAIL directed_out: got v=%0b d=%0d ch=%0d, want 1/2/12", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_sweep();
    mode = 1'b0; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) set_ch(i, 2'(i));
    for (int s = 0; s < N; s++) begin
      sel = 5'(s);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 5'(s) || out_data !== 2'(s)) begin
        n_err++;
        $display("FAIL sweep_%0d: got v=%0b d=%0d ch=%0d, want 1/%0d/%0d", s, out_valid, out_data, out_ch, s % 4, s);
      end
    end
    sel = 5'd31;
    #1;
    n_cmp++;
    if (in_ready !== 31'd0) begin
      n_err++;
      $display("FAIL sweep_sel31_ready: got %h, want 0", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_ch !== 5'd30) begin
      n_err++;
      $display("FAIL sweep_sel31_out: got v=%0b ch=%0d, want 0/30", out_valid, out_ch);
    end
`ifdef MUX_RR_SEL_ERR_EN
    n_cmp++;
    if (sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_sel_err: got %0b, want 1", sel_err);
    end
`endif
  endtask

  task automatic test_rr_sequence();
    int exp_seq[5] = '{3, 7, 30, 3, 7};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_valid[3] = 1'b1; in_valid[7] = 1'b1; in_valid[30] = 1'b1;
    in_data = {$urandom, $urandom};
    for (int j = 0; j < 5; j++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 5'(exp_seq[j])) begin
        n_err++;
        $display("FAIL rr_seq_%0d: got v=%0b ch=%0d, want 1/%0d", j, out_valid, out_ch, exp_seq[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_valid[5] = 1'b1;
    in_data = '0; set_ch(5, 2'b11);
    step();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_ch(5, 2'($urandom_range(0, 2)));
      #1;
      n_cmp++;
      if (in_ready !== 31'd0) begin
        n_err++;
        $display("FAIL bp_ready_%0d: got %h, want 0", j, in_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 5'd5 || out_data !== 2'b11) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%0b d=%0d ch=%0d, want 1/3/5", j, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    set_ch(5, 2'b01);
    #1;
    n_cmp++;
    if (in_ready !== (31'd1 << 5)) begin
      n_err++;
      $display("FAIL bp_drain_ready: got %h, want %h", in_ready, 31'd1 << 5);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 5'd5 || out_data !== 2'b01) begin
      n_err++;
      $display("FAIL bp_reload: got v=%0b d=%0d ch=%0d, want 1/1/5", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) set_ch(i, 2'b11);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || out_ch !== 5'd0 || in_ready !== 31'd0) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b d=%0d ch=%0d rdy=%h, want all 0", out_valid, out_data, out_ch, in_ready);
    end
    #2;
    reset = 1'b0;
    model_reset();
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset_first: got v=%0b ch=%0d, want 1/0", out_valid, out_ch);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    in_data = {$urandom, $urandom};
    repeat (5) step();
    n_cmp++;
    if (out_ch !== 5'd4) begin
      n_err++;
      $display("FAIL mode_rr_last: got ch=%0d, want 4", out_ch);
    end
    mode = 1'b0; sel = 5'd9;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 5'd9 || out_data !== in_data[9*W +: W]) begin
      n_err++;
      $display("FAIL mode_directed: got v=%0b ch=%0d, want 1/9", out_valid, out_ch);
    end
    mode = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 5'd5) begin
      n_err++;
      $display("FAIL mode_back_rr: got v=%0b ch=%0d, want 1/5", out_valid, out_ch);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        in_valid = '0;
        in_valid[$urandom_range(0, N - 1)] = 1'b1;
      end else begin
        in_valid = N'($urandom & $urandom & $urandom);
      end
      in_data = {$urandom, $urandom};
      #1;
      er = exp_ready();
      n_cmp++;
      if (in_ready !== er) begin
        n_err++;
        $display("FAIL rand_ready_%0d: got %h, want %h", c, in_ready, er);
      end
      step();
      n_cmp++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== 5'(m_ch)) begin
        n_err++;
        $display("FAIL rand_out_%0d: got v=%0b d=%0d ch=%0d, want %0b/%0d/%0d",
                 c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
`ifdef MUX_RR_SEL_ERR_EN
      n_cmp++;
      if (sel_err !== m_err) begin
        n_err++;
        $display("FAIL rand_sel_err_%0d: got %0b, want %0b", c, sel_err, m_err);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = 5'd0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_sweep();
    test_rr_sequence();
    test_backpressure();
    test_async_reset();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
